// File: rtl/stack_sort_pkg.sv
// stack_sort_pkg: shared types and constants for the
// base-die chip-ID sort initiator.
package stack_sort_pkg;

   localparam logic [15:0] SYNC_DFLT = 16'hBEAF;

   localparam logic [1:0] FT_ASSIGN = 2'b01;
   localparam logic [1:0] FT_REPORT = 2'b10;

   localparam int TYPE_LSB = 30;
   localparam int PWR_LSB  = 26;
   localparam int SRC_LSB  = 21;
   localparam int NXT_LSB  = 16;
   localparam int SYNC_LSB = 0;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      WAIT,
      DONE,
      ERR
   } state_e;

   typedef struct packed {
      logic [1:0]  ftype;
      logic [3:0]  power;
      logic [4:0]  src;
      logic [4:0]  nxt;
      logic [15:0] sync;
   } frame_t;

   function automatic logic [31:0] mk_assign(
      input logic [3:0]  pwr,
      input logic [15:0] sync
   );
      frame_t f;
      f.ftype = FT_ASSIGN;
      f.power = pwr;
      f.src   = 5'd0;
      f.nxt   = 5'd1;
      f.sync  = sync;
      return f;
   endfunction

endpackage

// File: rtl/stack_sort_master_check.sv
// sort_frame_check: combinational decode of a report frame
// against the source ID the collector expects next.
module sort_frame_check
   import stack_sort_pkg::*;
#(
   parameter logic [15:0] SYNC = SYNC_DFLT
) (
   input  logic [31:0] rx_data_i,
   input  logic [4:0]  exp_src_i,
   output logic        sync_ok_o,
   output logic        is_report_o,
   output logic        id_ok_o,
   output logic [3:0]  power_o
);

   logic [4:0] src;
   logic [4:0] nxt;

   assign src = rx_data_i[SRC_LSB +: 5];
   assign nxt = rx_data_i[NXT_LSB +: 5];

   assign sync_ok_o   = rx_data_i[SYNC_LSB +: 16] == SYNC;
   assign is_report_o = rx_data_i[TYPE_LSB +: 2] == FT_REPORT;
   assign id_ok_o     = (src == exp_src_i) &&
                        (nxt == src + 5'd1);
   assign power_o     = rx_data_i[PWR_LSB +: 4];

endmodule

// File: rtl/stack_sort_master.sv
// stack_sort_master: launches the assign frame, collects
// per-layer reports, and ends the sort on silence or max.
module stack_sort_master
   import stack_sort_pkg::*;
#(
   parameter int          TIMEOUT    = 64,
   parameter int          MAX_LAYERS = 31,
   parameter logic [15:0] SYNC       = SYNC_DFLT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  power_init,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] rx_data,
   input  logic        rx_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [4:0]  layer_count,
   input  logic [4:0]  rd_idx,
   output logic [3:0]  rd_power
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [4:0]    lc_q, lc_d;
   logic [31:0]   tx_q, tx_d;
   logic [3:0]    tbl_q [1:MAX_LAYERS];

   logic       tbl_clr;
   logic       tbl_we;
   logic [4:0] exp_src;
   logic       sync_ok;
   logic       is_report;
   logic       id_ok;
   logic [3:0] rx_pwr;
   logic       frame_ok;
   logic       acc;
   logic       rej;
   logic       tmo;

   assign exp_src = lc_q + 5'd1;

   sort_frame_check #(
      .SYNC(SYNC)
   ) u_chk (
      .rx_data_i   (rx_data),
      .exp_src_i   (exp_src),
      .sync_ok_o   (sync_ok),
      .is_report_o (is_report),
      .id_ok_o     (id_ok),
      .power_o     (rx_pwr)
   );

   // Classify the incoming frame for the WAIT state.
   always_comb begin
      frame_ok = rx_valid && sync_ok && is_report;
      acc      = (state_q == WAIT) && frame_ok && id_ok;
      rej      = (state_q == WAIT) && frame_ok && !id_ok;
      tmo      = cnt_q == TW'(TIMEOUT - 1);
   end

   // Next state, counters, assign frame and table strobes.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lc_d    = lc_q;
      tx_d    = tx_q;
      tbl_clr = 1'b0;
      tbl_we  = 1'b0;
      unique case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = SEND;
               lc_d    = 5'd0;
               tbl_clr = 1'b1;
               tx_d    = mk_assign(power_init, SYNC);
            end
         end
         SEND: begin
            if (tx_ready) begin
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (acc) begin
               tbl_we = 1'b1;
               lc_d   = exp_src;
               cnt_d  = '0;
               if (exp_src == 5'(MAX_LAYERS))
                  state_d = DONE;
            end else if (rej) begin
               state_d = ERR;
            end else if (tmo) begin
               state_d = (lc_q != 5'd0) ? DONE : ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and the outgoing frame register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         lc_q    <= 5'd0;
         tx_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lc_q    <= lc_d;
         tx_q    <= tx_d;
      end
   end

   // Per-layer power table, cleared on every new sort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 1; i <= MAX_LAYERS; i++)
            tbl_q[i] <= 4'd0;
      end else if (tbl_clr) begin
         for (int i = 1; i <= MAX_LAYERS; i++)
            tbl_q[i] <= 4'd0;
      end else if (tbl_we) begin
         for (int i = 1; i <= MAX_LAYERS; i++)
            if (exp_src == 5'(i))
               tbl_q[i] <= rx_pwr;
      end
   end

   // Table read; entries beyond layer_count read as 0.
   always_comb begin
      rd_power = 4'd0;
      for (int i = 1; i <= MAX_LAYERS; i++)
         if (rd_idx == 5'(i) && rd_idx <= lc_q)
            rd_power = tbl_q[i];
   end

   assign tx_data     = tx_q;
   assign tx_valid    = state_q == SEND;
   assign busy        = (state_q == SEND) ||
                        (state_q == WAIT);
   assign done        = (state_q == DONE) ||
                        (state_q == ERR);
   assign error       = state_q == ERR;
   assign layer_count = lc_q;

endmodule

// File: tb/tb_stack_sort_master.sv
// tb_stack_sort_master: directed table, corner sequences
// and randomized sorts against a plan-level model.
module tb_stack_sort_master;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  power_init = 4'd0;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] rx_data = 32'd0;
   logic        rx_valid = 1'b0;
   logic        busy, done, error;
   logic [4:0]  layer_count;
   logic [4:0]  rd_idx = 5'd0;
   logic [3:0]  rd_power;

   logic        b_start = 1'b0;
   logic [31:0] b_tx_data;
   logic        b_tx_valid;
   logic        b_tx_ready = 1'b0;
   logic [31:0] b_rx_data = 32'd0;
   logic        b_rx_valid = 1'b0;
   logic        b_busy, b_done, b_error;
   logic [4:0]  b_lc;
   logic [4:0]  b_rd_idx = 5'd0;
   logic [3:0]  b_rd_power;

   int n_chk = 0;
   int n_pass = 0;

   stack_sort_master #(
      .TIMEOUT(T), .MAX_LAYERS(31), .SYNC(16'hBEAF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .power_init(power_init), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .busy(busy), .done(done), .error(error),
      .layer_count(layer_count), .rd_idx(rd_idx),
      .rd_power(rd_power)
   );

   stack_sort_master #(
      .TIMEOUT(T), .MAX_LAYERS(2), .SYNC(16'hBEAF)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .start(b_start),
      .power_init(4'h2), .tx_data(b_tx_data),
      .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
      .rx_data(b_rx_data), .rx_valid(b_rx_valid),
      .busy(b_busy), .done(b_done), .error(b_error),
      .layer_count(b_lc), .rd_idx(b_rd_idx),
      .rd_power(b_rd_power)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] rx;
      logic [4:0]  lc;
      logic        err;
      logic        bsy;
   } vec_t;

   vec_t vt[5];

   function automatic logic [31:0] rep(
      input int s, input int n, input logic [3:0] p
   );
      return {2'b10, p, 5'(s), 5'(n), 16'hBEAF};
   endfunction

   task automatic chk(
      input string name,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h",
                    name, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [3:0] p);
      start = 1'b1;
      power_init = p;
      tick();
      start = 1'b0;
   endtask

   task automatic xfer(input int d);
      repeat (d) tick();
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
   endtask

   task automatic send(input logic [31:0] f);
      rx_data = f;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data = 32'd0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!done && n < 4 * T);
   endtask

   task automatic rd(input int i, input logic [3:0] e,
                     input string name);
      rd_idx = 5'(i);
      #1;
      chk(name, rd_power, e);
   endtask

   // One randomized sort: k good reports with random gaps
   // (noise allowed), then silence or a bad report.
   task automatic run_random();
      int k, g, n;
      bit bad;
      logic [3:0] pw[$];
      logic [3:0] p0;
      logic [31:0] nz;
      k = $urandom_range(0, 8);
      bad = ($urandom_range(0, 3) == 0);
      p0 = 4'($urandom);
      pw = {};
      do_start(p0);
      chk("rnd_txdata", tx_data,
          {2'b01, p0, 5'd0, 5'd1, 16'hBEAF});
      xfer($urandom_range(0, 3));
      for (int i = 0; i < k; i++) begin
         g = $urandom_range(0, T - 1);
         for (int j = 0; j < g; j++) begin
            if ($urandom_range(0, 1) == 1) begin
               nz = $urandom;
               if (nz[15:0] == 16'hBEAF) nz[31:30] = 2'b11;
               send(nz);
            end else begin
               tick();
            end
         end
         pw.push_back(4'($urandom));
         send(rep(i + 1, i + 2, pw[i]));
      end
      chk("rnd_busy", busy, 1'b1);
      if (bad) begin
         tick();
         send(rep(k + 2, k + 3, 4'h9));
         chk("rnd_bad_err", error, 1'b1);
      end else begin
         wait_done(n);
         chk("rnd_tmo_cycles", n, T);
         chk("rnd_err", error, k == 0);
      end
      chk("rnd_done", done, 1'b1);
      chk("rnd_lc", layer_count, 5'(k));
      for (int i = 1; i <= k; i++)
         rd(i, pw[i - 1], "rnd_tbl");
      rd(k + 1, 4'h0, "rnd_tbl_hi");
      rd(0, 4'h0, "rnd_tbl_zero");
   endtask

   initial begin
      int n, nv;

      vt[0] = '{rep(1, 2, 4'h3), 5'd1, 1'b0, 1'b1};
      vt[1] = '{{2'b10, 4'h4, 5'd2, 5'd3, 16'hDEAD},
                5'd1, 1'b0, 1'b1};
      vt[2] = '{{2'b01, 4'h9, 5'd2, 5'd3, 16'hBEAF},
                5'd1, 1'b0, 1'b1};
      vt[3] = '{rep(2, 3, 4'h7), 5'd2, 1'b0, 1'b1};
      vt[4] = '{rep(3, 4, 4'hF), 5'd3, 1'b0, 1'b1};

      // reset state
      tick();
      tick();
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_txd", tx_data, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", error, 1'b0);
      chk("rst_lc", layer_count, 5'd0);
      rd(1, 4'h0, "rst_tbl");
      rst_n = 1'b1;
      tick();

      // basic handshake with 3 stalled cycles
      do_start(4'h5);
      chk("hs_txd", tx_data, 32'h5401BEAF);
      chk("hs_busy", busy, 1'b1);
      nv = 0;
      repeat (3) begin
         if (tx_valid && tx_data == 32'h5401BEAF) nv++;
         tick();
      end
      tx_ready = 1'b1;
      if (tx_valid) nv++;
      tick();
      tx_ready = 1'b0;
      chk("hs_valid_cycles", nv, 4);
      chk("hs_txv_drop", tx_valid, 1'b0);
      chk("hs_busy_wait", busy, 1'b1);

      // three-layer stack with noise, table-driven
      for (int i = 0; i < 5; i++) begin
         send(vt[i].rx);
         chk("vec_lc", layer_count, vt[i].lc);
         chk("vec_err", error, vt[i].err);
         chk("vec_busy", busy, vt[i].bsy);
      end
      do_start(4'hA);
      chk("busy_start_txv", tx_valid, 1'b0);
      chk("busy_start_lc", layer_count, 5'd3);
      wait_done(n);
      chk("tmo_cycles", n + 1, T);
      chk("tmo_err", error, 1'b0);
      chk("tmo_busy", busy, 1'b0);
      chk("tmo_lc", layer_count, 5'd3);
      rd(2, 4'h7, "tbl2");
      rd(3, 4'hF, "tbl3");
      rd(4, 4'h0, "tbl4");
      rd(0, 4'h0, "tbl0");

      // restart from DONE
      rd_idx = 5'd2;
      do_start(4'hC);
      chk("rs_lc", layer_count, 5'd0);
      chk("rs_done", done, 1'b0);
      chk("rs_txv", tx_valid, 1'b1);
      chk("rs_txd", tx_data, 32'h7001BEAF);
      chk("rs_tbl", rd_power, 4'h0);
      xfer(0);

      // noise ignored, then an ID mismatch
      send({2'b10, 4'h1, 5'd1, 5'd2, 16'hDEAD});
      chk("nz_lc", layer_count, 5'd0);
      chk("nz_busy", busy, 1'b1);
      send(rep(2, 3, 4'h1));
      chk("rej_err", error, 1'b1);
      chk("rej_done", done, 1'b1);
      chk("rej_lc", layer_count, 5'd0);

      // empty stack
      do_start(4'h1);
      xfer(1);
      wait_done(n);
      chk("empty_cycles", n, T);
      chk("empty_err", error, 1'b1);
      chk("empty_lc", layer_count, 5'd0);

      // report on the threshold cycle keeps WAIT
      do_start(4'h2);
      xfer(0);
      repeat (T - 1) tick();
      send(rep(1, 2, 4'h6));
      chk("thr_busy", busy, 1'b1);
      chk("thr_done", done, 1'b0);
      chk("thr_lc", layer_count, 5'd1);
      wait_done(n);
      chk("thr_cycles", n, T);
      chk("thr_err", error, 1'b0);
      rd(1, 4'h6, "thr_tbl");

      // reset pulse during SEND
      do_start(4'h3);
      chk("rsnd_txv", tx_valid, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      chk("rsnd_txv0", tx_valid, 1'b0);
      chk("rsnd_busy", busy, 1'b0);
      chk("rsnd_txd", tx_data, 32'd0);
      chk("rsnd_done", done, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();

      // max-layers instance ends without a timeout wait
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_tx_ready = 1'b1;
      tick();
      b_tx_ready = 1'b0;
      b_rx_valid = 1'b1;
      b_rx_data = rep(1, 2, 4'hB);
      tick();
      b_rx_data = rep(2, 3, 4'hD);
      tick();
      b_rx_valid = 1'b0;
      chk("max_done", b_done, 1'b1);
      chk("max_err", b_error, 1'b0);
      chk("max_busy", b_busy, 1'b0);
      chk("max_lc", b_lc, 5'd2);
      b_rx_valid = 1'b1;
      b_rx_data = rep(3, 4, 4'h1);
      tick();
      b_rx_valid = 1'b0;
      chk("max_hold_lc", b_lc, 5'd2);
      b_rd_idx = 5'd2;
      #1;
      chk("max_tbl2", b_rd_power, 4'hD);

      // randomized sorts
      repeat (20) run_random();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
